muldiv_seq: RTL

//  Multi-cycle RV32M multiply/divide sequencer beside the EX-stage ALU.
//  - Accepts one M-extension op from ID/EX (funct7 = 0000001).
//  - Runs an iterative shift-add multiply or restoring divide, one bit per cycle.
//  - Holds the pipeline with stall until the result is ready.
//  - Returns the result and destination register for EX/MEM capture.

---
 rtl/muldiv_seq.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle RV32M multiply/divide sequencer that sits beside the
// EX-stage ALU. It accepts one M-extension op from ID/EX, then runs either an
// iterative shift-add multiply or a restoring divide at one bit per cycle. While
// the op runs it holds the pipeline with stall, and it returns the result and
// destination register for EX/MEM capture.
//
// Build option: define MULDIV_DIV_EN to include the divider. When it is not
// defined, no divider logic is built: every func3[2]=1 op completes in one cycle
// with result 0, and rdOut is still driven.
//
// Ports
//   clk     in   1     rising-edge clock
//   rst     in   1     asynchronous, active-high reset
//   start   in   1     ID/EX holds a valid M-op this cycle
//   func3   in   3     MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
//   opA     in   XLEN  rs1 value (post-forwarding)
//   opB     in   XLEN  rs2 value (post-forwarding)
//   rdIn    in   5     destination register
//   flush   in   1     kill of the op in EX
//   stall   out  1     freeze IF/ID/EX registers
//   busy    out  1     sequencer iterating
//   done    out  1     one-cycle pulse, result/rdOut valid
//   result  out  XLEN  final result (held until the next completion)
//   rdOut   out  5     destination register of the completed op
module muldiv_seq #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  input  logic [4:0]      rdIn,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rdOut
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_busy;
  logic                r_done;
  logic [2:0]          r_func3;
  logic [4:0]          r_rd;
  logic [XLEN-1:0]     r_mag_b;
  logic [2*XLEN-1:0]   r_acc;     // {hi, lo}: product, or {remainder, dividend/quotient}
  logic                r_neg;     // negate the final value
  logic [CNT_W-1:0]    r_cnt;
  logic [XLEN-1:0]     r_result;
  logic [4:0]          r_rd_out;

  // ---------------- operand conditioning at launch ----------------
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_sa;
  logic            w_sb;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic            w_neg;
  logic            w_launch;
  logic            w_special;
  logic [XLEN-1:0] w_special_res;

  always_comb begin
    w_a_signed = (func3 == 3'b001) || (func3 == 3'b010) ||
                 (func3 == 3'b100) || (func3 == 3'b110);
    w_b_signed = (func3 == 3'b001) || (func3 == 3'b100) || (func3 == 3'b110);
    w_sa       = w_a_signed & opA[XLEN-1];
    w_sb       = w_b_signed & opB[XLEN-1];
    w_mag_a    = w_sa ? (~opA + 1'b1) : opA;
    w_mag_b    = w_sb ? (~opB + 1'b1) : opB;
    // REM takes the dividend's sign; DIV and the high multiplies take sA^sB.
    if (func3[2] && func3[1]) w_neg = w_sa;
    else                      w_neg = w_sa ^ w_sb;
    w_launch   = (r_state == S_IDLE) && start && !flush;
  end

`ifdef MULDIV_DIV_EN
  logic w_div_zero;
  logic w_div_ovf;

  always_comb begin
    w_div_zero    = (opB == '0);
    w_div_ovf     = !func3[0] && (opA == {1'b1, {(XLEN-1){1'b0}}}) && (opB == '1);
    w_special     = func3[2] && (w_div_zero || w_div_ovf);
    w_special_res = '0;
    if (w_div_zero)   w_special_res = func3[1] ? opA : '1;
    else if (!func3[1]) w_special_res = opA;  // DIV overflow returns the dividend
  end
`else
  always_comb begin
    w_special     = func3[2];
    w_special_res = '0;
  end
`endif

  // ---------------- one iteration step ----------------
  logic [XLEN:0]      w_mul_sum;
  logic [2*XLEN-1:0]  w_mul_next;
  logic [2*XLEN-1:0]  w_acc_next;
  logic [2*XLEN-1:0]  w_prod;
  logic [XLEN-1:0]    w_mul_res;
  logic [XLEN-1:0]    w_final;

  always_comb begin
    w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_mag_b} : '0);
    w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};
  end

`ifdef MULDIV_DIV_EN
  logic [XLEN:0]      w_div_shift;
  logic [XLEN:0]      w_div_diff;
  logic               w_div_ge;
  logic [XLEN-1:0]    w_div_rem;
  logic [2*XLEN-1:0]  w_div_next;
  logic [XLEN-1:0]    w_div_sel;

  // Remainder stays below the divisor, so {rem, next dividend bit} fits XLEN+1 bits.
  always_comb begin
    w_div_shift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    w_div_diff  = w_div_shift - {1'b0, r_mag_b};
    w_div_ge    = (w_div_shift >= {1'b0, r_mag_b});
    w_div_rem   = w_div_ge ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0];
    w_div_next  = {w_div_rem, r_acc[XLEN-2:0], w_div_ge};
    w_acc_next  = r_func3[2] ? w_div_next : w_mul_next;
    w_div_sel   = r_func3[1] ? w_acc_next[2*XLEN-1:XLEN] : w_acc_next[XLEN-1:0];
  end
`else
  always_comb begin
    w_acc_next = w_mul_next;
  end
`endif

  always_comb begin
    w_prod    = r_neg ? (~w_acc_next + 1'b1) : w_acc_next;
    w_mul_res = (r_func3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
    w_final   = r_func3[2] ? (r_neg ? (~w_div_sel + 1'b1) : w_div_sel) : w_mul_res;
`else
    w_final   = r_func3[2] ? '0 : w_mul_res;
`endif
  end

  // ---------------- sequencer ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_func3  <= '0;
      r_rd     <= '0;
      r_mag_b  <= '0;
      r_acc    <= '0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_rd_out <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (w_launch) begin
            r_func3 <= func3;
            r_rd    <= rdIn;
            if (w_special) begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_result <= w_special_res;
              r_rd_out <= rdIn;
            end else begin
              r_state <= S_BUSY;
              r_busy  <= 1'b1;
              r_acc   <= {{XLEN{1'b0}}, w_mag_a};
              r_mag_b <= w_mag_b;
              r_neg   <= w_neg;
              r_cnt   <= '0;
            end
          end
        end
        S_BUSY: begin
          if (flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 1'b1;
            // Final iteration: the result is taken from the step's next value,
            // so DONE follows the XLEN-th BUSY cycle directly.
            if (r_cnt == CNT_W'(XLEN - 1)) begin
              r_state  <= S_DONE;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_result <= w_final;
              r_rd_out <= r_rd;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Launch term is combinational so the pipeline freezes in the start cycle;
  // reset forces it low so every output is 0 while rst is asserted.
  always_comb begin
    stall = !rst && (((r_state == S_IDLE) && start && !flush) || r_busy);
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign rdOut  = r_rd_out;

endmodule
